// File: rtl/if_id_flush_reg.sv
// rtl/if_id_flush_reg.sv - IF/ID pipeline register with redirect kill window
module if_id_flush_reg #(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] NOP_INST    = 32'h00000013,
    parameter int unsigned KILL_CYCLES = 2,
    parameter int unsigned CNT_W       = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ifid_in_pc,
    input  logic [31:0]     ifid_in_inst,
    input  logic            ifid_in_valid,
    input  logic            ifid_in_stall,
    input  logic            ifid_in_redirect,
    output logic [XLEN-1:0] ifid_out_pc,
    output logic [31:0]     ifid_out_inst,
    output logic            ifid_out_valid,
    output logic            ifid_out_bubble,
    output logic            ifid_out_kill_busy
);

    // The redirect slot is itself the first killed slot, so the counter holds the remainder.
    localparam logic [CNT_W-1:0] KILL_RELOAD = CNT_W'(KILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [XLEN-1:0]  pc_q,    pc_d;
    logic [31:0]      inst_q,  inst_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (ifid_in_redirect) begin
            pc_d    = ifid_in_pc;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            cnt_d   = KILL_RELOAD;
        end else if (cnt_q != '0) begin
            // Killed slots are only consumed when ID actually advances.
            if (!ifid_in_stall) begin
                pc_d    = ifid_in_pc;
                inst_d  = NOP_INST;
                valid_d = 1'b0;
                cnt_d   = cnt_q - CNT_ONE;
            end
        end else if (!ifid_in_stall) begin
            pc_d    = ifid_in_pc;
            inst_d  = ifid_in_valid ? ifid_in_inst : NOP_INST;
            valid_d = ifid_in_valid;
        end
    end

    assign ifid_out_pc        = pc_q;
    assign ifid_out_inst      = inst_q;
    assign ifid_out_valid     = valid_q;
    assign ifid_out_bubble    = !valid_q;
    assign ifid_out_kill_busy = (cnt_q != '0);

endmodule

// File: tb/tb_if_id_flush_reg.sv
// tb/tb_if_id_flush_reg.sv - directed vector bench for if_id_flush_reg
module tb_if_id_flush_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_pc, in_inst;
    logic        in_valid, in_stall, in_redirect;

    logic [31:0] pc2, inst2, pc3, inst3;
    logic        valid2, bubble2, busy2, valid3, bubble3, busy3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_flush_reg #(.KILL_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .ifid_in_pc(in_pc), .ifid_in_inst(in_inst), .ifid_in_valid(in_valid),
        .ifid_in_stall(in_stall), .ifid_in_redirect(in_redirect),
        .ifid_out_pc(pc2), .ifid_out_inst(inst2), .ifid_out_valid(valid2),
        .ifid_out_bubble(bubble2), .ifid_out_kill_busy(busy2)
    );

    if_id_flush_reg #(.KILL_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .ifid_in_pc(in_pc), .ifid_in_inst(in_inst), .ifid_in_valid(in_valid),
        .ifid_in_stall(in_stall), .ifid_in_redirect(in_redirect),
        .ifid_out_pc(pc3), .ifid_out_inst(inst3), .ifid_out_valid(valid3),
        .ifid_out_bubble(bubble3), .ifid_out_kill_busy(busy3)
    );

    typedef struct {
        logic        redir;
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_busy;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v,
                         input logic [31:0] p, input logic [31:0] i);
        in_redirect = r;
        in_stall    = s;
        in_valid    = v;
        in_pc       = p;
        in_inst     = i;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dut2(input string tag, input logic [31:0] p, input logic [31:0] i,
                              input logic v, input logic b);
        check({tag, ".pc2"},     pc2,     p);
        check({tag, ".inst2"},   inst2,   i);
        check({tag, ".valid2"},  {31'b0, valid2},  {31'b0, v});
        check({tag, ".bubble2"}, {31'b0, bubble2}, {31'b0, !v});
        check({tag, ".busy2"},   {31'b0, busy2},   {31'b0, b});
    endtask

    task automatic check_dut3(input string tag, input logic [31:0] p, input logic [31:0] i,
                              input logic v, input logic b);
        check({tag, ".pc3"},     pc3,     p);
        check({tag, ".inst3"},   inst3,   i);
        check({tag, ".valid3"},  {31'b0, valid3},  {31'b0, v});
        check({tag, ".bubble3"}, {31'b0, bubble3}, {31'b0, !v});
        check({tag, ".busy3"},   {31'b0, busy3},   {31'b0, b});
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic v,
                                input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] ep, input logic [31:0] ei,
                                input logic ev, input logic eb);
        vec_t t;
        t.redir = r; t.stall = s; t.valid = v; t.pc = p; t.inst = i;
        t.e_pc = ep; t.e_inst = ei; t.e_valid = ev; t.e_busy = eb;
        return t;
    endfunction

    initial begin
        // redir stall valid pc inst | exp pc, inst, valid, busy  (KILL_CYCLES=2)
        vecs[0]  = mk(0, 0, 1, 32'h100, 32'h00500093, 32'h100, 32'h00500093, 1, 0);
        vecs[1]  = mk(0, 0, 1, 32'h200, 32'h11111111, 32'h200, 32'h11111111, 1, 0);
        vecs[2]  = mk(1, 0, 1, 32'h204, 32'h22222222, 32'h204, NOP,          0, 1);
        vecs[3]  = mk(0, 0, 1, 32'h208, 32'h33333333, 32'h208, NOP,          0, 0);
        vecs[4]  = mk(0, 0, 1, 32'h208, 32'h44444444, 32'h208, 32'h44444444, 1, 0);
        vecs[5]  = mk(0, 0, 1, 32'h300, 32'h00A00113, 32'h300, 32'h00A00113, 1, 0);
        vecs[6]  = mk(0, 1, 1, 32'h304, 32'hAAAA0001, 32'h300, 32'h00A00113, 1, 0);
        vecs[7]  = mk(0, 1, 0, 32'h308, 32'hAAAA0002, 32'h300, 32'h00A00113, 1, 0);
        vecs[8]  = mk(0, 1, 1, 32'h30C, 32'hAAAA0003, 32'h300, 32'h00A00113, 1, 0);
        vecs[9]  = mk(0, 1, 0, 32'h310, 32'hAAAA0004, 32'h300, 32'h00A00113, 1, 0);
        vecs[10] = mk(0, 0, 0, 32'h310, 32'hDEADBEEF, 32'h310, NOP,          0, 0);
        vecs[11] = mk(1, 0, 1, 32'h400, 32'h55555555, 32'h400, NOP,          0, 1);
        vecs[12] = mk(1, 0, 1, 32'h404, 32'h66666666, 32'h404, NOP,          0, 1);
        vecs[13] = mk(0, 0, 1, 32'h408, 32'h77777777, 32'h408, NOP,          0, 0);
        vecs[14] = mk(0, 0, 1, 32'h40C, 32'h88888888, 32'h40C, 32'h88888888, 1, 0);
        vecs[15] = mk(1, 1, 1, 32'h500, 32'h99999999, 32'h500, NOP,          0, 1);
        vecs[16] = mk(0, 1, 1, 32'h504, 32'hBBBBBBBB, 32'h500, NOP,          0, 1);
        vecs[17] = mk(0, 0, 1, 32'h508, 32'hCCCCCCCC, 32'h508, NOP,          0, 0);
        vecs[18] = mk(0, 0, 1, 32'h50C, 32'hDDDDDDDD, 32'h50C, 32'hDDDDDDDD, 1, 0);

        rst = 1'b1;
        drive(0, 0, 1, 32'hFFF0, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            step();
            check_dut2($sformatf("reset%0d", c), 32'h0, NOP, 0, 0);
            check_dut3($sformatf("reset%0d", c), 32'h0, NOP, 0, 0);
        end
        rst = 1'b0;

        for (int k = 0; k < 19; k++) begin
            drive(vecs[k].redir, vecs[k].stall, vecs[k].valid, vecs[k].pc, vecs[k].inst);
            step();
            check_dut2($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_inst,
                       vecs[k].e_valid, vecs[k].e_busy);
        end

        // KILL_CYCLES=3: stalls inside the window freeze the counter
        drive(1, 0, 1, 32'h600, 32'h01010101);
        step();
        check_dut3("k3_redir", 32'h600, NOP, 0, 1);
        for (int s = 0; s < 2; s++) begin
            drive(0, 1, 1, 32'h700 + 32'(s), 32'h02020202);
            step();
            check_dut3($sformatf("k3_stall%0d", s), 32'h600, NOP, 0, 1);
        end
        drive(0, 0, 1, 32'h604, 32'h03030303);
        step();
        check_dut3("k3_slot2", 32'h604, NOP, 0, 1);
        drive(0, 0, 1, 32'h608, 32'h04040404);
        step();
        check_dut3("k3_slot3", 32'h608, NOP, 0, 0);
        drive(0, 0, 1, 32'h60C, 32'h05050505);
        step();
        check_dut3("k3_load", 32'h60C, 32'h05050505, 1, 0);

        // Async reset in the middle of a kill window
        drive(1, 0, 1, 32'h700, 32'h06060606);
        step();
        check_dut2("ar_pre", 32'h700, NOP, 0, 1);
        check_dut3("ar_pre", 32'h700, NOP, 0, 1);
        drive(0, 0, 1, 32'h704, 32'h07070707);
        #2;
        rst = 1'b1;
        #1;
        check_dut2("ar_async", 32'h0, NOP, 0, 0);
        check_dut3("ar_async", 32'h0, NOP, 0, 0);
        step();
        check_dut2("ar_hold", 32'h0, NOP, 0, 0);
        rst = 1'b0;
        drive(0, 0, 1, 32'h800, 32'h08080808);
        step();
        check_dut2("ar_load", 32'h800, 32'h08080808, 1, 0);
        check_dut3("ar_load", 32'h800, 32'h08080808, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
